dds_profile_controller: RTL and testbench
=========================================

Name: dds_profile_controller

Overview:
- Parametrised successor to the single-set DDS controller.
- Decodes 64-bit timed control words (from the GPO core's selected/gpo_out pair) into NUM_PROFILES shadow parameter sets.
- Commits a whole profile atomically to the DDS outputs.
- Adds a hardware linear frequency ramp; feeds the RFDC DDS block directly.

Parameters:
- NUM_PROFILES, 4, shadow profile count (1..4).
- FREQ_WIDTH, 48, frequency tuning word width (<=48).
- AMP_WIDTH, 14, amplitude and amp_offset width (<=14).
- PHASE_WIDTH, 14, phase width (<=14).
- TIME_OFFSET_WIDTH, 64, time_offset width (>=56).
- RAMP_DIV, 1, clock cycles per ramp step (>=1).

Ports:
- CLK100MHZ  in  1  sole clock.
- reset_n  in  1  reset.
- word_valid  in  1  control word strobe, one cycle per word.
- word_data  in  64  [63:60] opcode, [57:56] profile index, rest payload.
- freq  out  FREQ_WIDTH  active frequency.
- amp  out  AMP_WIDTH  active amplitude.
- phase  out  PHASE_WIDTH  active phase.
- amp_offset  out  AMP_WIDTH  active amplitude offset.
- time_offset  out  TIME_OFFSET_WIDTH  phase-reference time offset.
- active_profile  out  2  last committed profile.
- ramp_busy  out  1  ramp in progress.
- ramp_done  out  1  one-cycle pulse, ramp finished.
- update_strobe  out  1  one-cycle pulse when any output changes.
- op_error  out  1  one-cycle pulse, bad opcode or profile index.

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset: all outputs, shadows, ramp registers and state = 0; state IDLE.
- Payloads are taken from word LSBs and truncated to the parameter widths.
- Opcodes (P = profile index):
  - 0x0 SET_FREQ: shadow_freq[P] <= word[47:0].
  - 0x1 SET_AMP_PHASE: shadow_amp[P] <= [13:0]; shadow_phase[P] <= [29:16].
  - 0x2 SET_AMP_OFFSET: shadow_amp_offset[P] <= [13:0].
  - 0x3 SET_TIME_OFFSET: time_offset <= zero-extended [55:0]; applies immediately; update_strobe.
  - 0x4 COMMIT: freq/amp/phase/amp_offset <= shadow[P]; active_profile <= P; update_strobe; aborts any ramp (no ramp_done).
  - 0x5 SET_RAMP: ramp_step <= sign-extended [31:0]; ramp_count <= [47:32].
  - 0x6 RAMP_START: ramp begins from current freq. ramp_count = 0 -> stay IDLE; ramp_done pulses next cycle.
  - 0x7 RAMP_STOP: RAMP -> IDLE; freq holds; no ramp_done.
  - 0x8-0xF: ignored; op_error pulses.
- Profile check applies to ops 0x0/0x1/0x2/0x4 only: P >= NUM_PROFILES -> word ignored, op_error pulses.
- Latency: register writes and outputs take effect on the clock edge after word_valid; strobes are asserted in that same cycle.
- FSM IDLE/RAMP:
  - IDLE -> RAMP on RAMP_START with count > 0; load remaining = ramp_count; divider = 0.
  - In RAMP, divider counts 0..RAMP_DIV-1. On the wrap tick: freq <= freq + ramp_step (mod 2^FREQ_WIDTH, wraps silently); remaining--; update_strobe pulses.
  - When remaining reaches 0 on a tick: -> IDLE; ramp_done pulses in the same cycle as the final freq update.
  - ramp_busy = (state == RAMP).
- Simultaneous events:
  - COMMIT or RAMP_STOP on a ramp tick cycle: the control word wins; no step is applied.
  - RAMP_START during RAMP restarts from current freq with the latched count and step; divider is cleared.
  - SET_RAMP during RAMP updates the registers but does not affect the running ramp until the next RAMP_START (running step/remaining are separate copies).
  - Shadow writes never disturb outputs or the ramp.
- reset_n asserted mid-ramp: immediate return to reset state; no ramp_done.

Decomposition:
- dds_ctrl_pkg holds:
  - opcode enum (OP_SET_FREQ..OP_RAMP_STOP);
  - field bit-position localparams (OPCODE_MSB/LSB, PROFILE_MSB/LSB, RAMP_STEP/COUNT fields);
  - profile record struct (freq, amp, phase, amp_offset).
- One sub-module: dds_freq_ramp. It owns the IDLE/RAMP FSM, divider, remaining counter and the freq accumulator. Its inputs are load/start/stop and the step/count values.

Test Plan:
- Reset values: release reset_n; no words -> all outputs 0, ramp_busy 0, no strobes.
- Atomic profile commit:
  - SET_FREQ P2 = 0x0000_1234_5678, SET_AMP_PHASE P2 amp 0x1FFF phase 0x0800, then COMMIT P2.
  - Outputs stay unchanged until the COMMIT edge; then freq 0x123456780000 >> 16 truncated per width, i.e. 0x000012345678; amp 0x1FFF; phase 0x0800; active_profile 2.
  - update_strobe pulses exactly once.
- Ramp with RAMP_DIV = 4:
  - freq = 100, SET_RAMP step +10 count 3, RAMP_START.
  - freq is 110/120/130 at 4-cycle intervals; ramp_done pulses with 130; ramp_busy high for 12 cycles.
- Negative ramp wrap: freq = 5, step -10, count 1 -> freq = 2^48 - 5; ramp_done pulses.
- Abort:
  - COMMIT P0 during a count-100 ramp -> ramp_busy drops next cycle; freq = shadow P0; no ramp_done.
  - COMMIT arriving on a tick cycle -> no step is applied.
- Errors:
  - opcode 0x9 -> op_error pulses; no output change.
  - COMMIT with P = 3 when NUM_PROFILES = 2 -> op_error pulses; outputs unchanged.
  - RAMP_START with count 0 -> ramp_done pulses; ramp_busy stays 0.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// dds_ctrl_pkg: opcodes, control-word field positions and profile record for the DDS profile controller
package dds_ctrl_pkg;
    typedef enum logic [3:0] {
        OP_SET_FREQ        = 4'h0,
        OP_SET_AMP_PHASE   = 4'h1,
        OP_SET_AMP_OFFSET  = 4'h2,
        OP_SET_TIME_OFFSET = 4'h3,
        OP_COMMIT          = 4'h4,
        OP_SET_RAMP        = 4'h5,
        OP_RAMP_START      = 4'h6,
        OP_RAMP_STOP       = 4'h7
    } opcode_e;
    typedef enum logic {IDLE, RAMP} ramp_state_e;
    localparam int OPCODE_MSB      = 63;
    localparam int OPCODE_LSB      = 60;
    localparam int PROFILE_MSB     = 57;
    localparam int PROFILE_LSB     = 56;
    localparam int FREQ_MSB        = 47;
    localparam int AMP_MSB         = 13;
    localparam int PHASE_MSB       = 29;
    localparam int PHASE_LSB       = 16;
    localparam int TIME_OFFSET_MSB = 55;
    localparam int RAMP_STEP_MSB   = 31;
    localparam int RAMP_STEP_LSB   = 0;
    localparam int RAMP_COUNT_MSB  = 47;
    localparam int RAMP_COUNT_LSB  = 32;
    typedef struct packed {
        logic [47:0] freq;
        logic [13:0] amp;
        logic [13:0] phase;
        logic [13:0] amp_offset;
    } profile_t;
endpackage

// File: rtl/dds_freq_ramp.sv
// dds_freq_ramp: frequency accumulator with IDLE/RAMP linear ramp engine
module dds_freq_ramp
    import dds_ctrl_pkg::*;
#(
    parameter int FREQ_WIDTH = 48,
    parameter int RAMP_DIV   = 1
) (
    input  logic                  CLK100MHZ,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [FREQ_WIDTH-1:0] load_freq,
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           step,
    input  logic [15:0]           count,
    output logic [FREQ_WIDTH-1:0] freq,
    output logic                  busy,
    output logic                  done,
    output logic                  stepped
);
    localparam int DIV_W = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
    ramp_state_e           state;
    logic [FREQ_WIDTH-1:0] run_step;
    logic [FREQ_WIDTH-1:0] step_ext;
    logic [15:0]           remaining;
    logic [DIV_W-1:0]      div;
    logic                  wrap;
    assign step_ext = FREQ_WIDTH'({{16{step[31]}}, step});
    assign wrap     = div == DIV_W'(RAMP_DIV - 1);
    assign busy     = state == RAMP;
    // load/stop take priority over a coincident ramp tick
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            freq      <= '0;
            run_step  <= '0;
            remaining <= '0;
            div       <= '0;
            done      <= 1'b0;
            stepped   <= 1'b0;
        end else begin
            done    <= 1'b0;
            stepped <= 1'b0;
            if (load) begin
                freq  <= load_freq;
                state <= IDLE;
            end else if (stop) begin
                state <= IDLE;
            end else if (start) begin
                run_step  <= step_ext;
                remaining <= count;
                div       <= '0;
                state     <= count == '0 ? IDLE : RAMP;
                done      <= count == '0;
            end else if (state == RAMP) begin
                if (wrap) begin
                    div       <= '0;
                    freq      <= freq + run_step;
                    remaining <= remaining - 1'b1;
                    stepped   <= 1'b1;
                    if (remaining == 16'd1) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/dds_profile_controller.sv
// dds_profile_controller: decodes timed control words into shadow profiles and commits them atomically to the DDS
module dds_profile_controller
    import dds_ctrl_pkg::*;
#(
    parameter int NUM_PROFILES      = 4,
    parameter int FREQ_WIDTH        = 48,
    parameter int AMP_WIDTH         = 14,
    parameter int PHASE_WIDTH       = 14,
    parameter int TIME_OFFSET_WIDTH = 64,
    parameter int RAMP_DIV          = 1
) (
    input  logic                         CLK100MHZ,
    input  logic                         reset_n,
    input  logic                         word_valid,
    input  logic [63:0]                  word_data,
    output logic [FREQ_WIDTH-1:0]        freq,
    output logic [AMP_WIDTH-1:0]         amp,
    output logic [PHASE_WIDTH-1:0]       phase,
    output logic [AMP_WIDTH-1:0]         amp_offset,
    output logic [TIME_OFFSET_WIDTH-1:0] time_offset,
    output logic [1:0]                   active_profile,
    output logic                         ramp_busy,
    output logic                         ramp_done,
    output logic                         update_strobe,
    output logic                         op_error
);
    logic [3:0]  op;
    logic [1:0]  prof;
    profile_t    shadow [4];
    logic [31:0] ramp_step;
    logic [15:0] ramp_count;
    logic        uses_prof;
    logic        bad;
    logic        ok;
    logic        upd_r;
    logic        stepped;
    logic        unused_bits;
    assign op          = word_data[OPCODE_MSB:OPCODE_LSB];
    assign prof        = word_data[PROFILE_MSB:PROFILE_LSB];
    assign unused_bits = ^word_data[59:58];
    assign uses_prof   = op <= OP_COMMIT && op != OP_SET_TIME_OFFSET;
    assign bad         = word_valid && (op > OP_RAMP_STOP || (uses_prof && int'(prof) >= NUM_PROFILES));
    assign ok          = word_valid && !bad;
    assign update_strobe = upd_r | stepped;
    dds_freq_ramp #(
        .FREQ_WIDTH(FREQ_WIDTH),
        .RAMP_DIV  (RAMP_DIV)
    ) u_ramp (
        .CLK100MHZ(CLK100MHZ),
        .reset_n  (reset_n),
        .load     (ok && op == OP_COMMIT),
        .load_freq(shadow[prof].freq[FREQ_WIDTH-1:0]),
        .start    (ok && op == OP_RAMP_START),
        .stop     (ok && op == OP_RAMP_STOP),
        .step     (ramp_step),
        .count    (ramp_count),
        .freq     (freq),
        .busy     (ramp_busy),
        .done     (ramp_done),
        .stepped  (stepped)
    );
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
            amp            <= '0;
            phase          <= '0;
            amp_offset     <= '0;
            time_offset    <= '0;
            active_profile <= '0;
            ramp_step      <= '0;
            ramp_count     <= '0;
            upd_r          <= 1'b0;
            op_error       <= 1'b0;
        end else begin
            upd_r    <= ok && (op == OP_SET_TIME_OFFSET || op == OP_COMMIT);
            op_error <= bad;
            if (ok && op == OP_SET_FREQ)
                shadow[prof].freq <= word_data[FREQ_MSB:0];
            if (ok && op == OP_SET_AMP_PHASE) begin
                shadow[prof].amp   <= word_data[AMP_MSB:0];
                shadow[prof].phase <= word_data[PHASE_MSB:PHASE_LSB];
            end
            if (ok && op == OP_SET_AMP_OFFSET)
                shadow[prof].amp_offset <= word_data[AMP_MSB:0];
            if (ok && op == OP_SET_TIME_OFFSET)
                time_offset <= TIME_OFFSET_WIDTH'(word_data[TIME_OFFSET_MSB:0]);
            if (ok && op == OP_COMMIT) begin
                amp            <= shadow[prof].amp[AMP_WIDTH-1:0];
                phase          <= shadow[prof].phase[PHASE_WIDTH-1:0];
                amp_offset     <= shadow[prof].amp_offset[AMP_WIDTH-1:0];
                active_profile <= prof;
            end
            if (ok && op == OP_SET_RAMP) begin
                ramp_step  <= word_data[RAMP_STEP_MSB:RAMP_STEP_LSB];
                ramp_count <= word_data[RAMP_COUNT_MSB:RAMP_COUNT_LSB];
            end
        end
    end
endmodule

// File: tb/tb_dds_profile_controller.sv
// tb_dds_profile_controller: scoreboard bench for dds_profile_controller (4-profile and 2-profile instances)
module tb_dds_profile_controller;
    localparam logic [3:0] SET_FREQ = 4'h0, SET_AP = 4'h1, SET_AOFF = 4'h2, SET_TOFF = 4'h3;
    localparam logic [3:0] COMMIT = 4'h4, SET_RAMP = 4'h5, RSTART = 4'h6, RSTOP = 4'h7;
    logic        CLK100MHZ = 1'b0;
    logic        reset_n;
    logic        word_valid;
    logic [63:0] word_data;
    logic [47:0] freq, freq_b;
    logic [13:0] amp, phase, amp_offset, amp_b, phase_b, amp_offset_b;
    logic [63:0] time_offset, time_offset_b;
    logic [1:0]  active_profile, active_profile_b;
    logic        ramp_busy, ramp_done, update_strobe, op_error;
    logic        ramp_busy_b, ramp_done_b, update_strobe_b, op_error_b;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          base;
    typedef struct {
        int          at;
        string       tag;
        logic [47:0] freq;
        logic [13:0] amp, phase, aoff;
        logic [63:0] toff;
        logic [1:0]  prof;
        logic        busy, done, upd, err, chk2, err2;
        logic [47:0] freq2;
    } exp_t;
    exp_t        sb[$];
    logic [47:0] e_freq, e_freq2;
    logic [13:0] e_amp, e_phase, e_aoff;
    logic [63:0] e_toff;
    logic [1:0]  e_prof;
    logic        e_busy;
    dds_profile_controller #(.RAMP_DIV(4)) dut (
        .CLK100MHZ(CLK100MHZ), .reset_n(reset_n), .word_valid(word_valid), .word_data(word_data),
        .freq(freq), .amp(amp), .phase(phase), .amp_offset(amp_offset), .time_offset(time_offset),
        .active_profile(active_profile), .ramp_busy(ramp_busy), .ramp_done(ramp_done),
        .update_strobe(update_strobe), .op_error(op_error)
    );
    dds_profile_controller #(.NUM_PROFILES(2), .RAMP_DIV(4)) dut2 (
        .CLK100MHZ(CLK100MHZ), .reset_n(reset_n), .word_valid(word_valid), .word_data(word_data),
        .freq(freq_b), .amp(amp_b), .phase(phase_b), .amp_offset(amp_offset_b), .time_offset(time_offset_b),
        .active_profile(active_profile_b), .ramp_busy(ramp_busy_b), .ramp_done(ramp_done_b),
        .update_strobe(update_strobe_b), .op_error(op_error_b)
    );
    always #5 CLK100MHZ = ~CLK100MHZ;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp_v, cyc);
        end
    endtask
    task automatic push(input int at, input string tag, input logic upd, input logic done,
                        input logic err, input logic chk2, input logic err2);
        exp_t e;
        e.at = at; e.tag = tag; e.freq = e_freq; e.amp = e_amp; e.phase = e_phase; e.aoff = e_aoff;
        e.toff = e_toff; e.prof = e_prof; e.busy = e_busy; e.done = done; e.upd = upd; e.err = err;
        e.chk2 = chk2; e.err2 = err2; e.freq2 = e_freq2;
        sb.push_back(e);
    endtask
    task automatic send(input logic [3:0] op, input logic [1:0] p, input logic [55:0] pay);
        word_data  = {op, 2'b00, p, pay};
        word_valid = 1'b1;
        @(negedge CLK100MHZ);
        word_valid = 1'b0;
        word_data  = '0;
    endtask
    // one word: expected post-word state in its effect cycle, then a strobe-free cycle
    task automatic op1(input string tag, input logic [3:0] op, input logic [1:0] p, input logic [55:0] pay,
                       input logic upd, input logic err, input logic chk2, input logic err2);
        push(cyc + 1, tag, upd, 1'b0, err, chk2, err2);
        push(cyc + 2, {tag, "_after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(op, p, pay);
        @(negedge CLK100MHZ);
    endtask
    always @(posedge CLK100MHZ) begin
        exp_t e;
        #1;
        while (sb.size() > 0 && sb[0].at == cyc) begin
            e = sb.pop_front();
            check({e.tag, "/freq"}, freq, e.freq);
            check({e.tag, "/amp"}, amp, e.amp);
            check({e.tag, "/phase"}, phase, e.phase);
            check({e.tag, "/amp_offset"}, amp_offset, e.aoff);
            check({e.tag, "/time_offset"}, time_offset, e.toff);
            check({e.tag, "/active_profile"}, active_profile, e.prof);
            check({e.tag, "/ramp_busy"}, ramp_busy, e.busy);
            check({e.tag, "/ramp_done"}, ramp_done, e.done);
            check({e.tag, "/update_strobe"}, update_strobe, e.upd);
            check({e.tag, "/op_error"}, op_error, e.err);
            if (e.chk2) begin
                check({e.tag, "/np2_op_error"}, op_error_b, e.err2);
                check({e.tag, "/np2_freq"}, freq_b, e.freq2);
            end
        end
    end
    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        reset_n = 1'b0; word_valid = 1'b0; word_data = '0;
        e_freq = '0; e_freq2 = '0; e_amp = '0; e_phase = '0; e_aoff = '0; e_toff = '0; e_prof = '0; e_busy = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) push(cyc + k, "reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge CLK100MHZ);
        // shadow writes to P2 leave outputs alone; the 2-profile instance rejects P2
        op1("set_freq_p2", SET_FREQ, 2'd2, 56'h0000_1234_5678, 1'b0, 1'b0, 1'b1, 1'b1);
        op1("set_ampph_p2", SET_AP, 2'd2, 56'h0800_1FFF, 1'b0, 1'b0, 1'b1, 1'b1);
        op1("set_aoff_p2", SET_AOFF, 2'd2, 56'h0ABC, 1'b0, 1'b0, 1'b1, 1'b1);
        e_freq = 48'h0000_1234_5678; e_amp = 14'h1FFF; e_phase = 14'h0800; e_aoff = 14'h0ABC; e_prof = 2'd2;
        op1("commit_p2", COMMIT, 2'd2, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        e_toff = 64'h00AB_CDEF_0123_4567;
        op1("time_offset", SET_TOFF, 2'd0, 56'hAB_CDEF_0123_4567, 1'b1, 1'b0, 1'b1, 1'b0);
        op1("set_freq_p0", SET_FREQ, 2'd0, 56'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        e_freq = 48'd100; e_amp = '0; e_phase = '0; e_aoff = '0; e_prof = 2'd0; e_freq2 = 48'd100;
        op1("commit_p0", COMMIT, 2'd0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        op1("set_ramp_up", SET_RAMP, 2'd0, 56'h0003_0000_000A, 1'b0, 1'b0, 1'b0, 1'b0);
        base = cyc + 1;
        for (int k = 0; k < 14; k++) begin
            e_busy = k < 12;
            e_freq = 48'(100 + 10 * (k / 4));
            push(base + k, "ramp_up", k % 4 == 0 && k > 0, k == 12, 1'b0, 1'b0, 1'b0);
        end
        send(RSTART, 2'd0, '0);
        repeat (13) @(negedge CLK100MHZ);
        op1("set_freq_p1", SET_FREQ, 2'd1, 56'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        e_freq = 48'd5; e_prof = 2'd1; e_freq2 = 48'd5;
        op1("commit_p1", COMMIT, 2'd1, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        op1("set_ramp_neg", SET_RAMP, 2'd0, 56'h0001_FFFF_FFF6, 1'b0, 1'b0, 1'b0, 1'b0);
        base = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            e_busy = k < 4;
            e_freq = k < 4 ? 48'd5 : 48'hFFFF_FFFF_FFFB;
            e_freq2 = e_freq;
            push(base + k, "ramp_wrap", k == 4, k == 4, 1'b0, k == 4, 1'b0);
        end
        send(RSTART, 2'd0, '0);
        repeat (5) @(negedge CLK100MHZ);
        op1("set_ramp_100", SET_RAMP, 2'd0, 56'h0064_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        base = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            e_busy = k < 6;
            e_freq = k < 4 ? 48'hFFFF_FFFF_FFFB : (k < 6 ? 48'hFFFF_FFFF_FFFC : 48'd100);
            e_prof = k < 6 ? 2'd1 : 2'd0;
            push(base + k, "abort", k == 4 || k == 6, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send(RSTART, 2'd0, '0);
        repeat (5) @(negedge CLK100MHZ);
        send(COMMIT, 2'd0, '0);
        repeat (3) @(negedge CLK100MHZ);
        base = cyc + 1;
        for (int k = 0; k < 6; k++) begin
            e_busy = k < 4;
            e_freq = 48'd100;
            push(base + k, "tick_commit", k == 4, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send(RSTART, 2'd0, '0);
        repeat (3) @(negedge CLK100MHZ);
        send(COMMIT, 2'd0, '0);
        @(negedge CLK100MHZ);
        base = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            e_busy = k < 6;
            e_freq = k < 4 ? 48'd100 : 48'd101;
            push(base + k, "ramp_stop", k == 4, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send(RSTART, 2'd0, '0);
        repeat (5) @(negedge CLK100MHZ);
        send(RSTOP, 2'd0, '0);
        repeat (3) @(negedge CLK100MHZ);
        e_freq2 = 48'd101;
        op1("bad_opcode", 4'h9, 2'd0, 56'h1234, 1'b0, 1'b1, 1'b1, 1'b1);
        op1("set_ramp_zero", SET_RAMP, 2'd0, 56'h0000_0000_0005, 1'b0, 1'b0, 1'b0, 1'b0);
        base = cyc + 1;
        for (int k = 0; k < 6; k++) push(base + k, "ramp_zero", 1'b0, k == 0, 1'b0, k == 0, 1'b0);
        send(RSTART, 2'd0, '0);
        repeat (5) @(negedge CLK100MHZ);
        // P3 is valid on the 4-profile instance (zero shadow) but rejected by the 2-profile one
        e_freq = '0; e_prof = 2'd3;
        op1("commit_p3", COMMIT, 2'd3, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge CLK100MHZ);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
